// File: rtl/mealy_pkg.sv
// Shared types and constants for the Mealy detector and its serial bit feeder.
package mealy_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } ser_state_t;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_BIT_PERIOD = 1;

    // Detector state encodings (Gray-style walk A->B->C->D, E off to the side)
    localparam logic [2:0] DET_A = 3'b000;
    localparam logic [2:0] DET_B = 3'b001;
    localparam logic [2:0] DET_C = 3'b011;
    localparam logic [2:0] DET_D = 3'b010;
    localparam logic [2:0] DET_E = 3'b100;

endpackage

// File: rtl/sync_rise_detect.sv
// Multi-flop synchronizer for a pin-level strobe plus a one-cycle rising-edge pulse.
module sync_rise_detect #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic [STAGES-1:0] sync;
    logic              level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync    <= '0;
            level_q <= 1'b0;
        end else begin
            sync    <= {sync[STAGES-2:0], async_in};
            level_q <= sync[STAGES-1];
        end
    end

    assign rise = sync[STAGES-1] & ~level_q;

endmodule

// File: rtl/mealy_bit_serializer.sv
// Parallel-to-serial feeder for the detector's x1 input with busy/done handshake.
// Define PARITY_EN to append an even-parity bit after the data bits.
module mealy_bit_serializer
    import mealy_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter int BIT_PERIOD  = DEF_BIT_PERIOD
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           din,
    input  logic                       load,
    input  logic                       msb_first,
    output logic                       bit_out,
    output logic                       bit_valid,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(WIDTH+1)-1:0] bit_idx
);

    localparam int IW = $clog2(WIDTH+1);
`ifdef PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif

    ser_state_t       state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic             msb_q, msb_n;
    logic [7:0]       cnt, cnt_n;
    logic [IW-1:0]    idx_n;
    logic             bit_out_n, bit_valid_n, busy_n, done_n;
    logic             load_rise;
`ifdef PARITY_EN
    logic             par, par_n;
`endif

    sync_rise_detect #(.STAGES(SYNC_STAGES)) u_load_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (load),
        .rise     (load_rise)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shreg     <= '0;
            msb_q     <= 1'b0;
            cnt       <= '0;
            bit_idx   <= '0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef PARITY_EN
            par       <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            shreg     <= shreg_n;
            msb_q     <= msb_n;
            cnt       <= cnt_n;
            bit_idx   <= idx_n;
            bit_out   <= bit_out_n;
            bit_valid <= bit_valid_n;
            busy      <= busy_n;
            done      <= done_n;
`ifdef PARITY_EN
            par       <= par_n;
`endif
        end
    end

    // Outputs are computed one cycle ahead so bit_out/bit_valid come straight from flops.
    always_comb begin
        state_n     = state;
        shreg_n     = shreg;
        msb_n       = msb_q;
        cnt_n       = cnt;
        idx_n       = bit_idx;
        bit_out_n   = bit_out;
        bit_valid_n = bit_valid;
        busy_n      = busy;
        done_n      = 1'b0;
`ifdef PARITY_EN
        par_n       = par;
`endif
        case (state)
            IDLE: begin
                if (load_rise) begin
                    state_n     = SHIFT;
                    shreg_n     = din;
                    msb_n       = msb_first;
                    cnt_n       = '0;
                    idx_n       = '0;
                    bit_out_n   = msb_first ? din[WIDTH-1] : din[0];
                    bit_valid_n = 1'b1;
                    busy_n      = 1'b1;
`ifdef PARITY_EN
                    par_n       = ^din;
`endif
                end
            end
            SHIFT: begin
                if (cnt == 8'(BIT_PERIOD-1)) begin
                    cnt_n = '0;
                    if (bit_idx == IW'(NBITS-1)) begin
                        state_n     = DONE;
                        idx_n       = '0;
                        bit_out_n   = 1'b0;
                        bit_valid_n = 1'b0;
                        done_n      = 1'b1;
                    end else begin
                        shreg_n   = msb_q ? (shreg << 1) : (shreg >> 1);
                        idx_n     = bit_idx + IW'(1);
                        bit_out_n = msb_q ? shreg_n[WIDTH-1] : shreg_n[0];
`ifdef PARITY_EN
                        if (bit_idx == IW'(WIDTH-1))
                            bit_out_n = par;
`endif
                    end
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            DONE: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mealy_bit_serializer.sv
// Directed bench: two serializers (BIT_PERIOD 1 and 3) driven in parallel from one stimulus table.
module tb_mealy_bit_serializer;
    import mealy_pkg::*;

    localparam int W = 8;
`ifdef PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         load = 1'b0;
    logic         msb_first = 1'b0;
    logic [W-1:0] din = '0;

    logic         bo1, bv1, by1, dn1;
    logic [3:0]   ix1;
    logic         bo3, bv3, by3, dn3;
    logic [3:0]   ix3;

    mealy_bit_serializer #(.WIDTH(W), .SYNC_STAGES(2), .BIT_PERIOD(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .din(din), .load(load), .msb_first(msb_first),
        .bit_out(bo1), .bit_valid(bv1), .busy(by1), .done(dn1), .bit_idx(ix1)
    );

    mealy_bit_serializer #(.WIDTH(W), .SYNC_STAGES(2), .BIT_PERIOD(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .din(din), .load(load), .msb_first(msb_first),
        .bit_out(bo3), .bit_valid(bv3), .busy(by3), .done(dn3), .bit_idx(ix3)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " dut1 outs"}, {27'd0, bo1, bv1, by1, dn1, 1'b0} | 32'(ix1), 32'd0);
        chk({tag, " dut3 outs"}, {27'd0, bo3, bv3, by3, dn3, 1'b0} | 32'(ix3), 32'd0);
    endtask

    // seq[k] is the k-th bit presented; seq[8] is the even-parity bit of din
    typedef struct {
        logic [7:0] din;
        logic       msb;
        logic [8:0] seq;
    } vec_t;

    vec_t vt[5];
    int   n1, n3;

    initial begin
        vt[0] = '{din: 8'hA5, msb: 1'b0, seq: 9'h0A5};
        vt[1] = '{din: 8'hA5, msb: 1'b1, seq: 9'h0A5};
        vt[2] = '{din: 8'h02, msb: 1'b0, seq: 9'h102};
        vt[3] = '{din: 8'hC1, msb: 1'b1, seq: 9'h183};
        vt[4] = '{din: 8'h07, msb: 1'b0, seq: 9'h107};

        tick();
        tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        repeat (3) tick();

        for (int v = 0; v < 5; v++) begin
            din       = vt[v].din;
            msb_first = vt[v].msb;
            load      = 1'b1;
            tick();
            chk($sformatf("v%0d latency E", v), 32'(bv1), 32'd0);
            tick();
            chk($sformatf("v%0d latency E+1", v), 32'(bv1), 32'd0);
            n1 = 0;
            n3 = 0;
            for (int t = 0; t < 3*NB + 3; t++) begin
                tick();
                if (dn1) n1++;
                if (dn3) n3++;
                if (t < NB) begin
                    chk($sformatf("v%0d t%0d p1 bit", v, t), 32'(bo1), 32'(vt[v].seq[t]));
                    chk($sformatf("v%0d t%0d p1 idx", v, t), 32'(ix1), 32'(t));
                    chk($sformatf("v%0d t%0d p1 valid", v, t), 32'(bv1), 32'd1);
                end else if (t == NB) begin
                    chk($sformatf("v%0d p1 done", v), {30'd0, dn1, by1}, 32'd3);
                    chk($sformatf("v%0d p1 valid in done", v), 32'(bv1), 32'd0);
                end else begin
                    chk($sformatf("v%0d t%0d p1 idle", v, t), {30'd0, by1, bv1}, 32'd0);
                end
                if (t < 3*NB) begin
                    chk($sformatf("v%0d t%0d p3 bit", v, t), 32'(bo3), 32'(vt[v].seq[t/3]));
                    chk($sformatf("v%0d t%0d p3 idx", v, t), 32'(ix3), 32'(t/3));
                    chk($sformatf("v%0d t%0d p3 valid", v, t), 32'(bv3), 32'd1);
                end else if (t == 3*NB) begin
                    chk($sformatf("v%0d p3 done", v), {30'd0, dn3, by3}, 32'd3);
                end else begin
                    chk($sformatf("v%0d t%0d p3 idle", v, t), {30'd0, by3, bv3}, 32'd0);
                end
                // Load drops, inputs churn mid-shift, then a second rising edge is held across DONE.
                if (t == 0) load = 1'b0;
                if (t == 1) begin
                    din       = ~din;
                    msb_first = ~msb_first;
                end
                if (t == 5) load = 1'b1;
            end
            chk($sformatf("v%0d p1 done count", v), 32'(n1), 32'd1);
            chk($sformatf("v%0d p3 done count", v), 32'(n3), 32'd1);
            load = 1'b0;
            repeat (4) tick();
        end

        // Reset during bit 3 discards the word with no done pulse.
        din       = 8'hA5;
        msb_first = 1'b0;
        load      = 1'b1;
        tick();
        tick();
        tick();
        load = 1'b0;
        repeat (3) tick();
        chk("pre-reset p1 idx", 32'(ix1), 32'd3);
        rst_n = 1'b0;
        #1;
        chk_all_zero("async reset");
        tick();
        chk_all_zero("held reset");
        rst_n = 1'b1;
        n1 = 0;
        n3 = 0;
        for (int t = 0; t < 40; t++) begin
            tick();
            if (dn1) n1++;
            if (dn3) n3++;
        end
        chk("post-reset done count", 32'(n1 + n3), 32'd0);
        chk_all_zero("post-reset idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
